// File: rtl/fir_pkg.sv
// Shared types, legal parameter ranges and sizing helpers for the FIR family.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  localparam int unsigned TAPS_MIN = 2;
  localparam int unsigned TAPS_MAX = 32;

  // Accumulator width that can hold the sum of TAPS full-precision products.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Largest legal arithmetic right shift before saturation.
  function automatic int unsigned out_shift_max(input int unsigned data_w,
                                                input int unsigned coef_w);
    return data_w + coef_w - 1;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturate from ACC_W to DATA_W.
module fir_round_sat #(
  parameter int unsigned ACC_W     = 18,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  // One guard bit so adding the rounding bias can never wrap.
  localparam int unsigned SUM_W    = ACC_W + 1;
  localparam int unsigned BIAS_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [SUM_W-1:0] BIAS =
    (OUT_SHIFT > 0) ? ({{(SUM_W-1){1'b0}}, 1'b1} << BIAS_POS) : '0;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MIN_V = -MAX_V - SUM_W'(1);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  // Add bias, shift arithmetically, then clamp to the output range.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + BIAS;
    shifted = sum >>> OUT_SHIFT;
    if (shifted > MAX_V) begin
      y = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      y = MIN_V[DATA_W-1:0];
    end else begin
      y = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fir_mac_serial.sv
// Signed N-tap FIR with programmable coefficients and one time-shared multiplier.
module fir_mac_serial
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COEF_W    = 8,
  parameter int unsigned TAPS      = 4,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  x,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  y
);

  localparam int unsigned IDX_W  = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

  if (TAPS < TAPS_MIN || TAPS > TAPS_MAX) begin : g_bad_taps
    $error("fir_mac_serial: TAPS out of legal range 2..32");
  end
  if (OUT_SHIFT > out_shift_max(DATA_W, COEF_W)) begin : g_bad_shift
    $error("fir_mac_serial: OUT_SHIFT exceeds DATA_W+COEF_W-1");
  end

  fir_state_t                state;
  logic signed [DATA_W-1:0]  d [TAPS];
  logic signed [COEF_W-1:0]  c [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          idx;
  logic signed [PROD_W-1:0]  prod;
  logic signed [DATA_W-1:0]  y_next;

  assign in_ready = (state == IDLE);
  assign prod     = d[idx] * c[idx];

  fir_round_sat #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc (acc),
    .y   (y_next)
  );

  // Control FSM with delay line, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        d[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned i = 1; i < TAPS; i++) begin
              d[i] <= d[i-1];
            end
            d[0]  <= x;
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          // idx returns to 0 on the last tap so it never leaves 0..TAPS-1.
          if (idx == IDX_W'(TAPS - 1)) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          y         <= y_next;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coefficient bank: writes land only while idle and in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        c[i] <= '0;
      end
    end else if (state == IDLE && coef_we && int'(coef_addr) < int'(TAPS)) begin
      c[coef_addr] <= coef_data;
    end
  end

endmodule
